alu8_status: RTL

//   Result/flag stage directly downstream of alu8. On LOAD it captures alu8's F and CO

---
 rtl/alu8_status_pkg.sv | 48 ++++
 rtl/alu8_status_bcd_nibble_adj.sv | 22 ++
 rtl/alu8_status.sv | 139 +++++++++++++
 3 files changed

// File: rtl/alu8_status_pkg.sv
// Shared types and bit positions for the alu8 result/status stage.
package alu8_status_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADJ_LO = 2'd1,
    ADJ_HI = 2'd2
  } state_e;

  localparam int P_C = 0;
  localparam int P_Z = 1;
  localparam int P_I = 2;
  localparam int P_D = 3;
  localparam int P_B = 4;
  localparam int P_U = 5;
  localparam int P_V = 6;
  localparam int P_N = 7;

  localparam int U_C = 0;
  localparam int U_Z = 1;
  localparam int U_V = 2;
  localparam int U_N = 3;

  // Everything a decimal operation needs once the operand buses have moved on.
  typedef struct packed {
    logic       sub;
    logic       lo_fix;
    logic       hi_fix;
    logic       c;
    logic       n;
    logic       v;
    logic       z;
    logic [3:0] upd;
  } dec_ctx_t;

  function automatic logic [7:0] upd_flags(input logic [7:0] p, input logic [3:0] upd,
                                           input logic n, input logic v,
                                           input logic z, input logic c);
    logic [7:0] r;
    r = p;
    if (upd[U_N]) r[P_N] = n;
    if (upd[U_V]) r[P_V] = v;
    if (upd[U_Z]) r[P_Z] = z;
    if (upd[U_C]) r[P_C] = c;
    return r;
  endfunction

endpackage

// File: rtl/alu8_status_bcd_nibble_adj.sv
// Combinational BCD nibble correction: +6 (add) or -6 (sub) when enabled,
// with the carry/borrow that the correction pushes into the next nibble.
module bcd_nibble_adj
  import alu8_status_pkg::*;
(
  input  logic       en,
  input  logic       sub,
  input  logic [3:0] nib,
  output logic [3:0] nib_o,
  output logic       cy
);

  always_comb begin
    nib_o = nib;
    cy    = 1'b0;
    if (en) begin
      nib_o = sub ? (nib - 4'd6) : (nib + 4'd6);
      cy    = sub ? (nib < 4'd6) : (nib > 4'd9);
    end
  end

endmodule

// File: rtl/alu8_status.sv
// Result hold register and 6502 status register P behind alu8.
// Optional NMOS-style decimal adjust enabled by ALU8_STATUS_DECIMAL_EN.
module alu8_status
  import alu8_status_pkg::*;
#(
  parameter logic [7:0] P_RESET   = 8'h24,
  parameter logic [7:0] ADD_RESET = 8'h00
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       LOAD,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       CI,
  input  logic [7:0] F,
  input  logic       CO,
  input  logic       SUB,
  input  logic       DEC,
  input  logic [3:0] UPD,
  input  logic       PLOAD,
  input  logic [7:0] PSET,
  output logic [7:0] ADD,
  output logic [7:0] P,
  output logic       BUSY,
  output logic       VALID
);

`ifdef ALU8_STATUS_DECIMAL_EN
  localparam logic DEC_EN = 1'b1;
`else
  localparam logic DEC_EN = 1'b0;
`endif

  state_e     state_q, state_d;
  logic [7:0] add_q, add_d;
  logic [7:0] p_q, p_d;
  logic       valid_q, valid_d;
  logic [7:0] work_q, work_d;
  dec_ctx_t   ctx_q, ctx_d;

  logic       n_bin, z_bin, v_bin, lo_fix, hi_fix, dec_start;
  logic       adj_en, adj_cy;
  logic [3:0] adj_nib, adj_nib_o;

  // Binary flags and decimal-correction decisions, all taken from the LOAD-cycle inputs.
  always_comb begin
    n_bin     = F[7];
    z_bin     = (F == 8'h00);
    v_bin     = SUB ? ((A[7] ^ B[7]) & (A[7] ^ F[7])) : (~(A[7] ^ B[7]) & (A[7] ^ F[7]));
    lo_fix    = SUB ? ({1'b0, A[3:0]} < ({1'b0, B[3:0]} + {4'b0, ~CI}))
                    : (({1'b0, A[3:0]} + {1'b0, B[3:0]} + {4'b0, CI}) > 5'd9);
    hi_fix    = SUB ? ~CO : ({CO, F} > 9'h099);
    dec_start = DEC_EN & LOAD & DEC & p_q[P_D];
  end

  assign adj_en  = (state_q == ADJ_HI) ? ctx_q.hi_fix : ctx_q.lo_fix;
  assign adj_nib = (state_q == ADJ_HI) ? work_q[7:4] : work_q[3:0];

  bcd_nibble_adj u_adj (
    .en    (adj_en),
    .sub   (ctx_q.sub),
    .nib   (adj_nib),
    .nib_o (adj_nib_o),
    .cy    (adj_cy)
  );

  always_comb begin
    state_d = state_q;
    add_d   = add_q;
    p_d     = p_q;
    valid_d = 1'b0;
    work_d  = work_q;
    ctx_d   = ctx_q;
    unique case (state_q)
      IDLE: begin
        if (dec_start) begin
          work_d       = F;
          ctx_d.sub    = SUB;
          ctx_d.lo_fix = lo_fix;
          ctx_d.hi_fix = hi_fix;
          ctx_d.c      = SUB ? CO : hi_fix;
          ctx_d.n      = n_bin;
          ctx_d.v      = v_bin;
          ctx_d.z      = z_bin;
          ctx_d.upd    = UPD;
          state_d      = ADJ_LO;
        end else if (LOAD) begin
          add_d   = F;
          p_d     = upd_flags(p_q, UPD, n_bin, v_bin, z_bin, CO);
          valid_d = 1'b1;
        end
      end
      ADJ_LO: begin
        // The low-nibble correction ripples one unit into the high nibble.
        work_d  = {(ctx_q.sub ? (work_q[7:4] - {3'b0, adj_cy}) : (work_q[7:4] + {3'b0, adj_cy})),
                   adj_nib_o};
        state_d = ADJ_HI;
      end
      ADJ_HI: begin
        add_d   = {adj_nib_o, work_q[3:0]};
        p_d     = upd_flags(p_q, ctx_q.upd, ctx_q.n, ctx_q.v, ctx_q.z, ctx_q.c);
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (PLOAD) p_d = PSET;
    p_d[P_U] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      add_q   <= ADD_RESET;
      p_q     <= P_RESET | 8'h20;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      add_q   <= add_d;
      p_q     <= p_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge CLK) begin
    work_q <= work_d;
    ctx_q  <= ctx_d;
  end

  assign ADD   = add_q;
  assign P     = p_q;
  assign VALID = valid_q;
`ifdef ALU8_STATUS_DECIMAL_EN
  assign BUSY  = (state_q != IDLE);
`else
  assign BUSY  = 1'b0;
`endif

endmodule
